// File: rtl/game_hint_screen_if.sv
// rtl/game_hint_screen_if.sv - Control, pixel-index and pixel-data bundle for the hint screen
interface game_hint_screen_if;
  logic        enable;
  logic        frame_tick;
  logic        btn_c;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic        done;

  modport master (output enable, frame_tick, btn_c, x, y, input oled_data, done);
  modport slave  (input enable, frame_tick, btn_c, x, y, output oled_data, done);
endinterface

// File: rtl/game_hint_screen.sv
// rtl/game_hint_screen.sv - Animated PRESS/HOLD tutorial page with hold-to-complete FSM
module game_hint_screen #(
  parameter int          WIDTH        = 96,
  parameter int          HEIGHT       = 64,
  parameter int          BLINK_FRAMES = 15,
  parameter int          HOLD_FRAMES  = 60,
  parameter int          BAR_LEN      = 90,
  parameter logic [15:0] FG           = 16'hFFFF,
  parameter logic [15:0] BG           = 16'h0000,
  parameter logic [15:0] ACCENT       = 16'h07E0
) (
  input  logic              clk,
  input  logic              rst_n,
  game_hint_screen_if.slave bus
);

  localparam int HW    = $clog2(HOLD_FRAMES + 1);
  localparam int BW    = $clog2(BLINK_FRAMES + 1);
  localparam int TXT_X = 3;

  localparam logic [2:0] CH_P = 3'd0;
  localparam logic [2:0] CH_R = 3'd1;
  localparam logic [2:0] CH_E = 3'd2;
  localparam logic [2:0] CH_S = 3'd3;
  localparam logic [2:0] CH_H = 3'd4;
  localparam logic [2:0] CH_O = 3'd5;
  localparam logic [2:0] CH_L = 3'd6;
  localparam logic [2:0] CH_D = 3'd7;

  localparam logic [14:0] TXT_PRESS = {CH_P, CH_R, CH_E, CH_S, CH_S};
  localparam logic [14:0] TXT_HOLD  = {CH_H, CH_O, CH_L, CH_D, 3'd0};

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_vis;
  logic          btn_prev;
  logic          btn_rise;
  logic          done_next;
  logic          done_q;
  logic [15:0]   pix;
  logic [15:0]   pix_q;

  int            xi;
  int            yi;
  int            hold_i;
  int            hand_top;
  int            hand_bot;
  logic          bob;
  logic          hand_edge;

  // Glyph rows packed MSB-first, leftmost column is bit 3 of each row
  function automatic logic font_bit(input logic [2:0] ch, input int row, input int col);
    logic [19:0] g;
    case (ch)
      CH_P:    g = 20'b1110_1001_1110_1000_1000;
      CH_R:    g = 20'b1110_1001_1110_1010_1001;
      CH_E:    g = 20'b1111_1000_1110_1000_1111;
      CH_S:    g = 20'b0111_1000_0110_0001_1110;
      CH_H:    g = 20'b1001_1001_1111_1001_1001;
      CH_O:    g = 20'b0110_1001_1001_1001_0110;
      CH_L:    g = 20'b1000_1000_1000_1000_1111;
      default: g = 20'b1110_1001_1001_1001_1110;
    endcase
    return g[5'(19 - row * 4 - col)];
  endfunction

  function automatic logic text_on(input int px, input int py, input int oy,
                                   input logic [14:0] codes, input int n);
    logic hit;
    int   cx;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cx = px - TXT_X - 5 * i;
      if (i < n && py >= oy && py < oy + 5 && cx >= 0 && cx < 4)
        hit = font_bit(3'(codes >> (12 - 3 * i)), py - oy, cx);
    end
    return hit;
  endfunction

  assign btn_rise = bus.btn_c & ~btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      btn_prev <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= 16'h0000;
    end else begin
      state    <= state_next;
      btn_prev <= bus.btn_c;
      done_q   <= done_next;
      pix_q    <= pix;
    end
  end

  // Release and disable are checked before the completing tick so they win
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (!bus.enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = PRESS;
        PRESS: if (btn_rise) state_next = HOLD;
        HOLD: begin
          if (!bus.btn_c) begin
            state_next = PRESS;
          end else if (bus.frame_tick && hold_cnt == HW'(HOLD_FRAMES - 1)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (state_next == IDLE) begin
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else begin
      if (state == PRESS && state_next == HOLD) begin
        blink_cnt <= '0;
        blink_vis <= 1'b1;
      end else if (bus.frame_tick && (state == PRESS || state == HOLD)) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_vis <= ~blink_vis;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (state == HOLD && state_next == PRESS)
        hold_cnt <= '0;
      else if (state == HOLD && bus.frame_tick && bus.btn_c && hold_cnt != HW'(HOLD_FRAMES))
        hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_comb begin
    xi        = {25'd0, bus.x};
    yi        = {26'd0, bus.y};
    hold_i    = {{(32 - HW){1'b0}}, hold_cnt};
    bob       = bus.btn_c && (state == PRESS || state == HOLD);
    hand_top  = bob ? 9 : 7;
    hand_bot  = bob ? 51 : 49;
    hand_edge = xi >= 30 && xi <= 60 && yi >= hand_top && yi <= hand_bot &&
                (xi <= 31 || xi >= 59 || yi <= hand_top + 1 || yi >= hand_bot - 1);
    pix       = BG;
    if (state != IDLE && xi < WIDTH && yi < HEIGHT) begin
      if (((state == PRESS && blink_vis) || state == DONE) &&
          text_on(xi, yi, 12, TXT_PRESS, 5)) begin
        pix = FG;
      end else if (((state == HOLD && blink_vis) || state == DONE) &&
                   text_on(xi, yi, 24, TXT_HOLD, 4)) begin
        pix = FG;
      end else if (hand_edge) begin
        pix = FG;
      end else if (xi >= 43 && xi <= 59 && yi >= 53 && yi <= 62 &&
                   (xi == 43 || xi == 59 || yi == 53 || yi == 62)) begin
        pix = FG;
      end else if (xi >= 45 && xi <= 57 && yi >= 55 && yi <= 59) begin
        pix = bus.btn_c ? ACCENT : BG;
      end else if (yi == 2 || yi == 3) begin
        // Fill compare is cross-multiplied so no divider is needed
        if (xi == 2 || xi == 3 + BAR_LEN)
          pix = FG;
        else if (xi >= 3 && xi <= 2 + BAR_LEN &&
                 (state == DONE || (xi - 3) * HOLD_FRAMES < hold_i * BAR_LEN))
          pix = ACCENT;
      end
    end
  end

  assign bus.oled_data = pix_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_game_hint_screen.sv
// tb/tb_game_hint_screen.sv - Directed self-checking bench for game_hint_screen
module tb_game_hint_screen;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   done0_cnt;
  int   done_at;

  game_hint_screen_if if0();
  game_hint_screen_if if1();

  game_hint_screen u0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  game_hint_screen #(.BLINK_FRAMES(2), .HOLD_FRAMES(1), .BAR_LEN(10))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(negedge clk) if (if0.done) done0_cnt <= done0_cnt + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [6:0] px, input logic [5:0] py);
    if0.x = px; if0.y = py;
    if1.x = px; if1.y = py;
    step();
  endtask

  task automatic tick0();
    if0.frame_tick = 1'b1;
    step();
    if0.frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; done_at = 0;
    rst_n = 1'b0;
    if0.enable = 1'b0; if0.frame_tick = 1'b0; if0.btn_c = 1'b0; if0.x = '0; if0.y = '0;
    if1.enable = 1'b0; if1.frame_tick = 1'b0; if1.btn_c = 1'b0; if1.x = '0; if1.y = '0;
    repeat (3) step();
    check("rst_pix", if0.oled_data, 16'h0000);
    check("rst_done", 16'(if0.done), 16'h0000);
    rst_n = 1'b1;

    pix(2, 2);    check("idle_bar_cap", if0.oled_data, 16'h0000);
    pix(30, 7);   check("idle_hand", if0.oled_data, 16'h0000);

    if0.enable = 1'b1;
    step();
    pix(3, 12);   check("press_txt", if0.oled_data, 16'hFFFF);
    pix(2, 2);    check("bar_cap_l", if0.oled_data, 16'hFFFF);
    pix(93, 2);   check("bar_cap_r", if0.oled_data, 16'hFFFF);
    pix(92, 2);   check("bar_empty", if0.oled_data, 16'h0000);
    pix(50, 57);  check("cap_empty", if0.oled_data, 16'h0000);
    pix(43, 53);  check("btn_outline", if0.oled_data, 16'hFFFF);
    pix(100, 10); check("oor_x", if0.oled_data, 16'h0000);
    pix(3, 24);   check("no_hold_txt", if0.oled_data, 16'h0000);

    repeat (15) tick0();
    pix(3, 12);   check("blink_off", if0.oled_data, 16'h0000);
    repeat (14) tick0();
    pix(3, 12);   check("blink_still_off", if0.oled_data, 16'h0000);
    tick0();
    pix(3, 12);   check("blink_on", if0.oled_data, 16'hFFFF);

    if0.x = 50; if0.y = 57; if0.btn_c = 1'b1;
    step();
    check("cap_fill", if0.oled_data, 16'h07E0);
    pix(30, 9);   check("hand_bob", if0.oled_data, 16'hFFFF);
    pix(30, 7);   check("hand_old_top", if0.oled_data, 16'h0000);
    pix(3, 24);   check("hold_txt", if0.oled_data, 16'hFFFF);
    pix(3, 12);   check("press_txt_gone", if0.oled_data, 16'h0000);

    repeat (30) tick0();
    pix(3, 2);    check("bar_start", if0.oled_data, 16'h07E0);
    pix(47, 2);   check("bar_last_fill", if0.oled_data, 16'h07E0);
    pix(48, 2);   check("bar_first_empty", if0.oled_data, 16'h0000);
    if0.btn_c = 1'b0;
    step();
    pix(3, 2);    check("early_bar_clr", if0.oled_data, 16'h0000);
    pix(3, 12);   check("early_press_txt", if0.oled_data, 16'hFFFF);
    check("early_no_done", 16'(done0_cnt), 16'h0000);

    if0.btn_c = 1'b1;
    step();
    repeat (59) tick0();
    if0.frame_tick = 1'b1; if0.btn_c = 1'b0;
    step();
    if0.frame_tick = 1'b0;
    check("rel_wins_done", 16'(if0.done), 16'h0000);
    pix(3, 2);    check("rel_wins_bar", if0.oled_data, 16'h0000);
    check("rel_wins_cnt", 16'(done0_cnt), 16'h0000);

    if0.btn_c = 1'b1; if0.frame_tick = 1'b1;
    step();
    if0.frame_tick = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick0();
      if (if0.done && done_at == 0) done_at = i;
    end
    check("done_tick", 16'(done_at), 16'd60);
    step();
    check("done_width", 16'(if0.done), 16'h0000);
    check("done_count", 16'(done0_cnt), 16'd1);
    pix(92, 3);   check("done_bar_end", if0.oled_data, 16'h07E0);
    pix(93, 3);   check("done_bar_cap", if0.oled_data, 16'hFFFF);
    pix(3, 12);   check("done_press_txt", if0.oled_data, 16'hFFFF);
    pix(3, 24);   check("done_hold_txt", if0.oled_data, 16'hFFFF);
    pix(40, 9);   check("done_no_bob", if0.oled_data, 16'h0000);
    pix(50, 57);  check("done_cap_fill", if0.oled_data, 16'h07E0);

    if0.enable = 1'b0; if0.btn_c = 1'b0;
    step();
    pix(2, 2);    check("off_bar_cap", if0.oled_data, 16'h0000);
    pix(43, 53);  check("off_btn", if0.oled_data, 16'h0000);

    if0.enable = 1'b1;
    step();
    if0.btn_c = 1'b1;
    step();
    repeat (10) tick0();
    pix(2, 2);    check("pre_rst_pix", if0.oled_data, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_pix", if0.oled_data, 16'h0000);
    check("rst_async_done", 16'(if0.done), 16'h0000);
    if0.enable = 1'b0; if0.btn_c = 1'b0;
    step();
    rst_n = 1'b1;
    pix(2, 2);    check("post_rst_bar", if0.oled_data, 16'h0000);
    pix(3, 12);   check("post_rst_txt", if0.oled_data, 16'h0000);
    check("post_rst_done", 16'(done0_cnt), 16'd1);

    if1.enable = 1'b1;
    step();
    pix(3, 2);    check("p_bar_empty", if1.oled_data, 16'h0000);
    pix(13, 2);   check("p_cap_r", if1.oled_data, 16'hFFFF);
    if1.btn_c = 1'b1;
    step();
    if1.frame_tick = 1'b1;
    step();
    if1.frame_tick = 1'b0;
    check("p_done", 16'(if1.done), 16'h0001);
    pix(12, 2);   check("p_bar_end", if1.oled_data, 16'h07E0);
    check("p_done_width", 16'(if1.done), 16'h0000);
    pix(3, 3);    check("p_bar_start", if1.oled_data, 16'h07E0);
    pix(13, 3);   check("p_cap_r3", if1.oled_data, 16'hFFFF);
    pix(14, 2);   check("p_past_cap", if1.oled_data, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
